// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude select (one-hot: x1 or x2, neither means 0) plus negate bit.
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_digit_t;

  function automatic int digit_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to a digit in {-2..+2}.
module booth_r4_digit_enc
  import booth_mul_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  // 3'b111 maps to a plain zero so no negated-zero term ever reaches the adder.
  always_comb begin
    digit = '0;
    case (window)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100:         begin digit.two = 1'b1; digit.neg = 1'b1; end
      3'b101, 3'b110: begin digit.one = 1'b1; digit.neg = 1'b1; end
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier retiring one digit per clock.
// Flag registers are built only when BOOTH_MUL_FLAGS_EN is defined.
module booth_mul_iter
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               alu_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               neg_flag,
  output logic               zero_flag
);

  localparam int D     = digit_count(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam int MW    = WIDTH + 3;
  localparam int CNT_W = $clog2(D);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [MW-1:0]     mplr_q, mplr_d;
  logic [PW-1:0]     product_q, product_d;

  booth_digit_t      digit;
  logic [PW-1:0]     mag;
  logic [PW-1:0]     term;
  logic [PW-1:0]     sum;
  logic              accept;
  logic              finish;

  booth_r4_digit_enc u_enc (
    .window (mplr_q[2:0]),
    .digit  (digit)
  );

  assign accept = (state_q == IDLE) && in_valid && in_ready_q;
  assign finish = (state_q == RUN) && (cnt_q == LAST);

  // The multiplicand shifts left by two each cycle, so it already carries 4^i.
  always_comb begin
    mag = '0;
    if (digit.two) begin
      mag = mcand_q << 1;
    end else if (digit.one) begin
      mag = mcand_q;
    end
    term = digit.neg ? ('0 - mag) : mag;
    sum  = acc_q + term;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = '0;
          cnt_d   = '0;
          mcand_d = {{WIDTH{alu_signed & a[WIDTH-1]}}, a};
          mplr_d  = {{2{alu_signed & b[WIDTH-1]}}, b, 1'b0};
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + CNT_W'(1);
        if (finish) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      product_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplr_q     <= mplr_d;
      product_q  <= product_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

`ifdef BOOTH_MUL_FLAGS_EN
  logic signed_q, signed_d;
  logic neg_q, neg_d;
  logic zero_q, zero_d;

  always_comb begin
    signed_d = signed_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    if (accept) begin
      signed_d = alu_signed;
    end
    if (finish) begin
      neg_d  = signed_q & sum[PW-1];
      zero_d = (sum == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      signed_q <= signed_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
    end
  end

  assign neg_flag  = neg_q;
  assign zero_flag = zero_q;
`else
  assign neg_flag  = 1'b0;
  assign zero_flag = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter against an arithmetic reference model.
module tb_booth_mul_iter;

  localparam int W  = 16;
  localparam int D  = W / 2 + 1;
`ifdef BOOTH_MUL_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          alu_signed;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic          neg_flag;
  logic          zero_flag;

  int errors = 0;
  int checks = 0;

  booth_mul_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_signed (alu_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .neg_flag   (neg_flag),
    .zero_flag  (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer multiplication of the interpreted operand values.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    longint sx, sy, p;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  function automatic logic ref_neg(input logic [2*W-1:0] p, input logic s);
    return FLAGS_EN && s && p[2*W-1];
  endfunction

  function automatic logic ref_zero(input logic [2*W-1:0] p);
    return FLAGS_EN && (p == '0);
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input bit ack, output logic [2*W-1:0] p, output logic n,
                        output logic z, output int lat, output bit ok);
    int wait_n;
    ok = 1'b1;
    lat = 0;
    p = '0;
    n = 1'b0;
    z = 1'b0;
    @(negedge clk);
    wait_n = 0;
    while (!in_ready && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    a = ta;
    b = tb;
    alu_signed = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    alu_signed = 1'($urandom);
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    p = product;
    n = neg_flag;
    z = zero_flag;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, product, neg_flag, zero_flag} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b prod=%h n=%b z=%b required all 0",
               in_ready, out_valid, product, neg_flag, zero_flag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: got rdy=%b vld=%b required rdy=1 vld=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{16'hFFFD, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h1234};
    logic [W-1:0] vb [6] = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h0000};
    logic         vs [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2*W-1:0] p, exp_p;
    logic n, z;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b1, p, n, z, lat, ok);
      exp_p = ref_prod(va[i], vb[i], vs[i]);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL directed_timeout[%0d]: handshake did not complete", i);
        continue;
      end
      checks++;
      if (p !== exp_p) begin
        errors++;
        $display("[TB] FAIL directed_product[%0d]: got %h required %h", i, p, exp_p);
      end
      checks++;
      if (n !== ref_neg(exp_p, vs[i]) || z !== ref_zero(exp_p)) begin
        errors++;
        $display("[TB] FAIL directed_flags[%0d]: got n=%b z=%b required n=%b z=%b",
                 i, n, z, ref_neg(exp_p, vs[i]), ref_zero(exp_p));
      end
      checks++;
      if (lat != D) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d required %0d", i, lat, D);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rs;
    logic [2*W-1:0] p, exp_p;
    logic n, z;
    int lat;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 8 == 7) ? '0 : W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, 1'b1, p, n, z, lat, ok);
      exp_p = ref_prod(ra, rb, rs);
      checks++;
      if (!ok || p !== exp_p || n !== ref_neg(exp_p, rs) || z !== ref_zero(exp_p)) begin
        errors++;
        $display("[TB] FAIL random[%0d] a=%h b=%h s=%b: got ok=%b p=%h n=%b z=%b required p=%h n=%b z=%b",
                 i, ra, rb, rs, ok, p, n, z, exp_p, ref_neg(exp_p, rs), ref_zero(exp_p));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] p, exp_p;
    logic n, z;
    int lat;
    bit ok;
    run_op(16'hFFFD, 16'h0005, 1'b1, 1'b0, p, n, z, lat, ok);
    exp_p = ref_prod(16'hFFFD, 16'h0005, 1'b1);
    checks++;
    if (!ok || p !== exp_p) begin
      errors++;
      $display("[TB] FAIL bp_result: got ok=%b p=%h required %h", ok, p, exp_p);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0];
      a = 16'h0002;
      b = 16'h0003;
      alu_signed = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp_p ||
          neg_flag !== ref_neg(exp_p, 1'b1) || zero_flag !== ref_zero(exp_p)) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b p=%h n=%b z=%b required vld=1 rdy=0 p=%h",
                 c, out_valid, in_ready, product, neg_flag, zero_flag, exp_p);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    repeat (D + 3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || product !== exp_p) begin
      errors++;
      $display("[TB] FAIL bp_no_accept: got vld=%b p=%h required vld=0 p=%h",
               out_valid, product, exp_p);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int ov_cnt = 0;
    int exp_ov = 0;
    logic [2*W-1:0] exp_p;
    exp_p = ref_prod(16'd300, 16'd500, 1'b0);
    a = 16'd300;
    b = 16'd500;
    alu_signed = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready) acc_cyc.push_back(c);
      if (out_valid) begin
        ov_cnt++;
        checks++;
        if (product !== exp_p) begin
          errors++;
          $display("[TB] FAIL b2b_product: got %h required %h", product, exp_p);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    foreach (acc_cyc[k]) if (acc_cyc[k] + D < 40) exp_ov++;
    checks++;
    if (acc_cyc.size() < 3) begin
      errors++;
      $display("[TB] FAIL b2b_accepts: got %0d required at least 3", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != D + 2 || acc_cyc[2] - acc_cyc[1] != D + 2) begin
      errors++;
      $display("[TB] FAIL b2b_interval: got %0d,%0d required %0d",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], D + 2);
    end
    checks++;
    if (ov_cnt != exp_ov) begin
      errors++;
      $display("[TB] FAIL b2b_valid_cycles: got %0d required %0d", ov_cnt, exp_ov);
    end
    repeat (D + 3) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] p;
    logic n, z;
    int lat;
    int wait_n = 0;
    bit ok;
    @(negedge clk);
    while (!in_ready && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    a = 16'hABCD;
    b = 16'h9876;
    alu_signed = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, product, neg_flag, zero_flag} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got rdy=%b vld=%b prod=%h n=%b z=%b required all 0",
               in_ready, out_valid, product, neg_flag, zero_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd7, 16'd9, 1'b0, 1'b1, p, n, z, lat, ok);
    checks++;
    if (!ok || p !== 32'h0000003F || n !== 1'b0 || z !== 1'b0 || lat != D) begin
      errors++;
      $display("[TB] FAIL midrun_recover: got ok=%b p=%h n=%b z=%b lat=%0d required p=0000003f n=0 z=0 lat=%0d",
               ok, p, n, z, lat, D);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    alu_signed = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_iter.md
# booth_mul_iter

Parametrised, iterative radix-4 Booth multiplier with a valid/ready handshake on both sides. It retires one Booth digit per clock, so the area is a single encoder and adder rather than a full partial-product tree. It serves as the low-area, multi-cycle alternative to the single-cycle 16x16 Booth/tree/CLA datapath. It adds configurable operand width, per-operation signed/unsigned mode, backpressure and registered result flags.

## Interface
- WIDTH, 16: operand width in bits. Must be even and at least 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- alu_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- product  output  2*WIDTH  full product.
- neg_flag  output  1  result negative.
- zero_flag  output  1  result is zero.

## Operation
- Digit count: D = WIDTH/2 + 1. With WIDTH = 16, D = 9.
- Accept: when in_valid and in_ready are both high on a clock edge, the block:
  - latches a, b and alu_signed;
  - clears the accumulator and digit counter;
  - enters RUN.
- Operand extension:
  - Multiplicand is extended to 2*WIDTH: sign-extended when signed, zero-extended when unsigned.
  - Multiplier is extended to WIDTH+2 by the same rule, then a 0 is appended below the LSB.
  - The extra top digit makes unsigned operands exact.
- Each RUN cycle, for digit index i from 0 to D-1:
  - Bits 2i+1, 2i and 2i-1 of the extended multiplier select a digit in {-2, -1, 0, +1, +2}.
  - The accumulator adds digit x multiplicand x 4^i, computed modulo 2^(2*WIDTH).
- Result: after D cycles the product is exact, with no truncation error, for every operand pair in both modes.
- States:
  - IDLE: in_ready = 1, out_valid = 0. Goes to RUN on accept.
  - RUN: in_ready = 0. Goes to DONE when the counter reaches D-1.
  - DONE: out_valid = 1. Goes to IDLE when out_ready is high.
- In DONE, product and the flags are registered and held stable until the handshake completes.
- in_valid is ignored outside IDLE.
- a, b and alu_signed may change freely after accept.
- out_ready is ignored outside DONE.
- Flags:
  - zero_flag = (product == 0).
  - neg_flag = alu_signed_latched AND product[2*WIDTH-1]. It is always 0 for unsigned results.

## Timing
- Reset values: in_ready = 0 while rst is asserted, then 1 from the first edge in IDLE. out_valid = 0. product = 0. neg_flag = 0. zero_flag = 0. State is IDLE.
- Latency: accept at edge t. out_valid rises after edge t+D and is seen high in cycle t+D.
- Throughput: at most one operation per D+2 cycles when out_ready is held high. DONE and IDLE each take one cycle, so there is no back-to-back overlap.
- Result handshake: completes on the edge where out_valid and out_ready are both high. out_valid is low in the next cycle. product keeps its last value until the next result is loaded.
- Reset mid-operation: any state goes to IDLE immediately and all outputs take their reset values. The in-flight operation is discarded and no result is produced.

## Configuration
- BOOTH_MUL_FLAGS_EN defined:
  - the neg_flag and zero_flag registers and their comparison logic are built;
  - the flags update in the same cycle as product.
- BOOTH_MUL_FLAGS_EN undefined:
  - both flag ports are still present but tied to 0;
  - no flag logic is synthesised.
- Port list is identical in both builds.

## Structure
- Shared package booth_mul_pkg:
  - the state enumeration (IDLE, RUN, DONE);
  - the Booth digit encoding type, a one-hot or sign/magnitude select of {0, 1, 2} plus a negate bit;
  - a function computing D from WIDTH.
- Sub-module booth_r4_digit_enc: combinational; maps a 3-bit multiplier window to the digit select and negate bit. The top level holds the accumulator, counter and FSM.

## Test plan
- Signed, WIDTH = 16, a = 0xFFFD (-3), b = 0x0005 -> product 0xFFFFFFF1, neg_flag = 1, zero_flag = 0. out_valid high exactly 9 cycles after the accept edge.
- Unsigned, a = 0xFFFF, b = 0xFFFF -> product 0xFFFE0001, neg_flag = 0. The same operands signed -> 0x00000001.
- Signed corner cases:
  - a = 0x8000, b = 0x8000 -> 0x40000000, neg_flag = 0.
  - a = 0x8000, b = 0x0001 -> 0xFFFF8000, neg_flag = 1.
- Zero result: a = 0x1234, b = 0x0000, unsigned -> product 0, zero_flag = 1. In a build without BOOTH_MUL_FLAGS_EN both flags stay 0.
- Backpressure: hold out_ready low for 5 cycles in DONE and pulse in_valid during that time. Required: product, flags and out_valid stay stable; in_ready = 0; the pulsed operands are not accepted. After out_ready rises, in_ready = 1 one cycle later.
- Reset mid-run: assert rst 4 cycles after accept. Required: all outputs are reset values immediately. After release, a new op 7 x 9 (unsigned) -> 0x0000003F, with no residue from the aborted op.
